scoreboard: RTL and testbench

Register scoreboard for the Stage-3 dual-issue pipeline. Tracks in-flight architectural-register writers and pending loads per register, from issue until writeback or load-data return. It consumes the per-slot issue decisions of the issue stage and feeds back `busy_vec` and `load_pending_vec`. Per-register counters allow several outstanding writers to the same `rd`: slot0 may issue over a busy `rd`.

---
 rtl/rv32i_pkg.sv | 12 +
 rtl/scoreboard_counter.sv | 48 ++++
 rtl/scoreboard.sv | 113 +++++++++++
 tb/tb_scoreboard.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared pipeline definitions: register-file geometry and scoreboard event types.
package rv32i_pkg;

    localparam int unsigned NUM_ARCH_REGS = 32;
    localparam int unsigned SB_CNT_W      = 2;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
    } sb_event_t;

endpackage

// File: rtl/scoreboard_counter.sv
// Saturating up/down counter for one register, taking up to two increments and two
// decrements per cycle; the two error flags report any attempted overflow or underflow.
module sb_counter
    import rv32i_pkg::*;
#(
    parameter int unsigned CNT_W = SB_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] inc_cnt,
    input  logic [1:0] dec_cnt,
    input  logic       clr,
    output logic       nonzero,
    output logic       ovf,
    output logic       unf
);

    // Two guard bits: one for a +2 carry and one as the sign of a -2 result.
    localparam int unsigned SumW = CNT_W + 2;
    localparam logic [SumW-1:0] CntMax = SumW'((1 << CNT_W) - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SumW-1:0]  sum;

    always_comb begin
        sum = SumW'(cnt_q) + SumW'(inc_cnt) - SumW'(dec_cnt);
        unf = !clr && sum[SumW-1];
        ovf = !clr && !sum[SumW-1] && (sum > CntMax);
        if (clr || unf) begin
            cnt_d = '0;
        end else if (ovf) begin
            cnt_d = CntMax[CNT_W-1:0];
        end else begin
            cnt_d = sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign nonzero = |cnt_q;

endmodule

// File: rtl/scoreboard.sv
// Dual-issue register scoreboard: per-register writer and load counters driven by the
// issue, writeback and load-return events, with a sticky counter-error flag.
module scoreboard
    import rv32i_pkg::*;
#(
    parameter int unsigned CNT_W = SB_CNT_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iss0_valid,
    input  logic [4:0]  iss0_rd,
    input  logic        iss0_reg_write,
    input  logic        iss0_is_load,
    input  logic        iss1_valid,
    input  logic [4:0]  iss1_rd,
    input  logic        iss1_reg_write,
    input  logic        iss1_is_load,
    input  logic        wb0_valid,
    input  logic [4:0]  wb0_rd,
    input  logic        wb1_valid,
    input  logic [4:0]  wb1_rd,
    input  logic        ld_done_valid,
    input  logic [4:0]  ld_done_rd,
    input  logic        flush_all,
    output logic [31:0] busy_vec,
    output logic [31:0] load_pending_vec,
    output logic        sb_err
);

    logic [1:0] w_inc [NUM_ARCH_REGS];
    logic [1:0] w_dec [NUM_ARCH_REGS];
    logic [1:0] l_inc [NUM_ARCH_REGS];
    logic [1:0] l_dec [NUM_ARCH_REGS];

    logic       iss0_set, iss1_set;
    logic       wb0_clr, wb1_clr, ld_clr;

    logic [NUM_ARCH_REGS-1:0] w_ovf, w_unf, l_ovf, l_unf;
    logic                     sb_err_q;

    assign iss0_set = iss0_valid && iss0_reg_write && (iss0_rd != 5'd0);
    assign iss1_set = iss1_valid && iss1_reg_write && (iss1_rd != 5'd0);
    assign wb0_clr  = wb0_valid && (wb0_rd != 5'd0);
    assign wb1_clr  = wb1_valid && (wb1_rd != 5'd0);
    assign ld_clr   = ld_done_valid && (ld_done_rd != 5'd0);

    // Events aimed at the same register accumulate, so each counter sees 0..2 per side.
    always_comb begin
        for (int i = 0; i < NUM_ARCH_REGS; i++) begin
            w_inc[i] = '0;
            w_dec[i] = '0;
            l_inc[i] = '0;
            l_dec[i] = '0;
        end
        if (iss0_set) begin
            w_inc[iss0_rd] = w_inc[iss0_rd] + 2'd1;
            if (iss0_is_load) l_inc[iss0_rd] = l_inc[iss0_rd] + 2'd1;
        end
        if (iss1_set) begin
            w_inc[iss1_rd] = w_inc[iss1_rd] + 2'd1;
            if (iss1_is_load) l_inc[iss1_rd] = l_inc[iss1_rd] + 2'd1;
        end
        if (wb0_clr) w_dec[wb0_rd] = w_dec[wb0_rd] + 2'd1;
        if (wb1_clr) w_dec[wb1_rd] = w_dec[wb1_rd] + 2'd1;
        if (ld_clr)  l_dec[ld_done_rd] = l_dec[ld_done_rd] + 2'd1;
    end

    assign busy_vec[0]         = 1'b0;
    assign load_pending_vec[0] = 1'b0;
    assign w_ovf[0]            = 1'b0;
    assign w_unf[0]            = 1'b0;
    assign l_ovf[0]            = 1'b0;
    assign l_unf[0]            = 1'b0;

    for (genvar g = 1; g < NUM_ARCH_REGS; g++) begin : g_reg
        sb_counter #(
            .CNT_W (CNT_W)
        ) u_wcnt (
            .clk     (clk),
            .rst     (rst),
            .inc_cnt (w_inc[g]),
            .dec_cnt (w_dec[g]),
            .clr     (flush_all),
            .nonzero (busy_vec[g]),
            .ovf     (w_ovf[g]),
            .unf     (w_unf[g])
        );

        sb_counter #(
            .CNT_W (CNT_W)
        ) u_lcnt (
            .clk     (clk),
            .rst     (rst),
            .inc_cnt (l_inc[g]),
            .dec_cnt (l_dec[g]),
            .clr     (flush_all),
            .nonzero (load_pending_vec[g]),
            .ovf     (l_ovf[g]),
            .unf     (l_unf[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_err_q <= 1'b0;
        end else if (|{w_ovf, w_unf, l_ovf, l_unf}) begin
            sb_err_q <= 1'b1;
        end
    end

    assign sb_err = sb_err_q;

endmodule

// File: tb/tb_scoreboard.sv
// Scoreboard bench: directed scenarios followed by random traffic, all checked against an
// integer-count reference model of the per-register writers and loads.
module tb_scoreboard;

    localparam int CNT_W  = 2;
    localparam int CntMax = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        iss0_valid, iss0_reg_write, iss0_is_load;
    logic [4:0]  iss0_rd;
    logic        iss1_valid, iss1_reg_write, iss1_is_load;
    logic [4:0]  iss1_rd;
    logic        wb0_valid, wb1_valid, ld_done_valid, flush_all;
    logic [4:0]  wb0_rd, wb1_rd, ld_done_rd;
    logic [31:0] busy_vec, load_pending_vec;
    logic        sb_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: outstanding writer and load counts per register.
    int wm[32];
    int lm[32];
    bit em;

    always #5 clk = ~clk;

    scoreboard #(
        .CNT_W (CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .iss0_valid       (iss0_valid),
        .iss0_rd          (iss0_rd),
        .iss0_reg_write   (iss0_reg_write),
        .iss0_is_load     (iss0_is_load),
        .iss1_valid       (iss1_valid),
        .iss1_rd          (iss1_rd),
        .iss1_reg_write   (iss1_reg_write),
        .iss1_is_load     (iss1_is_load),
        .wb0_valid        (wb0_valid),
        .wb0_rd           (wb0_rd),
        .wb1_valid        (wb1_valid),
        .wb1_rd           (wb1_rd),
        .ld_done_valid    (ld_done_valid),
        .ld_done_rd       (ld_done_rd),
        .flush_all        (flush_all),
        .busy_vec         (busy_vec),
        .load_pending_vec (load_pending_vec),
        .sb_err           (sb_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        rst = 1'b0;
        iss0_valid = 1'b0; iss0_rd = '0; iss0_reg_write = 1'b0; iss0_is_load = 1'b0;
        iss1_valid = 1'b0; iss1_rd = '0; iss1_reg_write = 1'b0; iss1_is_load = 1'b0;
        wb0_valid = 1'b0; wb0_rd = '0; wb1_valid = 1'b0; wb1_rd = '0;
        ld_done_valid = 1'b0; ld_done_rd = '0; flush_all = 1'b0;
    endtask

    // Apply this cycle's inputs to the reference counts.
    task automatic model_step();
        int dw[32];
        int dl[32];
        for (int r = 0; r < 32; r++) begin
            dw[r] = 0;
            dl[r] = 0;
        end
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                wm[r] = 0;
                lm[r] = 0;
            end
            em = 1'b0;
        end else if (flush_all) begin
            for (int r = 0; r < 32; r++) begin
                wm[r] = 0;
                lm[r] = 0;
            end
        end else begin
            if (iss0_valid && iss0_reg_write && iss0_rd != 0) begin
                dw[iss0_rd] += 1;
                if (iss0_is_load) dl[iss0_rd] += 1;
            end
            if (iss1_valid && iss1_reg_write && iss1_rd != 0) begin
                dw[iss1_rd] += 1;
                if (iss1_is_load) dl[iss1_rd] += 1;
            end
            if (wb0_valid && wb0_rd != 0) dw[wb0_rd] -= 1;
            if (wb1_valid && wb1_rd != 0) dw[wb1_rd] -= 1;
            if (ld_done_valid && ld_done_rd != 0) dl[ld_done_rd] -= 1;
            for (int r = 1; r < 32; r++) begin
                wm[r] += dw[r];
                lm[r] += dl[r];
                if (wm[r] > CntMax) begin wm[r] = CntMax; em = 1'b1; end
                if (wm[r] < 0)      begin wm[r] = 0;      em = 1'b1; end
                if (lm[r] > CntMax) begin lm[r] = CntMax; em = 1'b1; end
                if (lm[r] < 0)      begin lm[r] = 0;      em = 1'b1; end
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [31:0] eb, el;
        eb = '0;
        el = '0;
        for (int r = 1; r < 32; r++) begin
            eb[r] = (wm[r] != 0);
            el[r] = (lm[r] != 0);
        end
        check_eq({tag, ".busy"}, busy_vec, eb);
        check_eq({tag, ".ldpend"}, load_pending_vec, el);
        check_eq({tag, ".err"}, {31'd0, sb_err}, {31'd0, em});
    endtask

    // Inputs are already set; update the model, clock once and compare just after the edge.
    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_model(tag);
        clear_inputs();
    endtask

    task automatic iss0(input logic [4:0] rd, input logic ld);
        iss0_valid = 1'b1; iss0_rd = rd; iss0_reg_write = 1'b1; iss0_is_load = ld;
    endtask

    task automatic iss1(input logic [4:0] rd, input logic ld);
        iss1_valid = 1'b1; iss1_rd = rd; iss1_reg_write = 1'b1; iss1_is_load = ld;
    endtask

    function automatic logic [4:0] pick_rd();
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin
        for (int r = 0; r < 32; r++) begin
            wm[r] = 0;
            lm[r] = 0;
        end
        em = 1'b0;
        clear_inputs();
        @(negedge clk);

        rst = 1'b1;
        step("reset");
        check_eq("reset.busy_zero", busy_vec, 32'h0);

        // Single writer then writeback.
        iss0(5'd5, 1'b0);
        step("addi_x5");
        check_eq("addi_x5.busy_const", busy_vec, 32'h0000_0020);
        step("idle1");
        wb0_valid = 1'b1; wb0_rd = 5'd5;
        step("wb_x5");
        check_eq("wb_x5.busy_const", busy_vec, 32'h0);

        // Load: load-pending clears at ld_done, busy at writeback.
        iss0(5'd7, 1'b1);
        step("lw_x7");
        ld_done_valid = 1'b1; ld_done_rd = 5'd7;
        step("lddone_x7");
        check_eq("lddone_x7.busy7", {31'd0, busy_vec[7]}, 32'd1);
        wb1_valid = 1'b1; wb1_rd = 5'd7;
        step("wb_x7");

        // Multiple writers to x3.
        iss0(5'd3, 1'b0);
        step("x3_w1");
        iss0(5'd3, 1'b0);
        step("x3_w2");
        wb0_valid = 1'b1; wb0_rd = 5'd3;
        step("x3_wb1");
        check_eq("x3_wb1.busy3", {31'd0, busy_vec[3]}, 32'd1);
        wb0_valid = 1'b1; wb0_rd = 5'd3;
        step("x3_wb2");
        iss0(5'd3, 1'b0);
        step("x3_w3");
        iss0(5'd3, 1'b0); wb1_valid = 1'b1; wb1_rd = 5'd3;
        step("x3_same_cycle");
        check_eq("x3_same_cycle.busy3", {31'd0, busy_vec[3]}, 32'd1);
        iss0(5'd3, 1'b0); iss1(5'd3, 1'b0);
        step("x3_dual_issue");
        wb0_valid = 1'b1; wb0_rd = 5'd3; wb1_valid = 1'b1; wb1_rd = 5'd3;
        step("x3_dual_wb");
        wb0_valid = 1'b1; wb0_rd = 5'd3;
        step("x3_drain");

        // Register 0 and non-writing issues leave no trace.
        iss0(5'd0, 1'b1); iss1_valid = 1'b1; iss1_rd = 5'd6; iss1_is_load = 1'b1;
        wb0_valid = 1'b1; wb0_rd = 5'd0; ld_done_valid = 1'b1; ld_done_rd = 5'd0;
        step("x0");
        check_eq("x0.err_const", {31'd0, sb_err}, 32'd0);

        // Saturation makes the error sticky.
        for (int k = 0; k < 4; k++) begin
            iss0(5'd9, 1'b0);
            step("x9_sat");
        end
        check_eq("x9_sat.err_const", {31'd0, sb_err}, 32'd1);
        wb0_valid = 1'b1; wb0_rd = 5'd4;
        step("underflow_x4");
        for (int k = 0; k < 3; k++) begin
            wb0_valid = 1'b1; wb0_rd = 5'd9;
            step("x9_drain");
        end
        check_eq("x9_drain.busy9", {31'd0, busy_vec[9]}, 32'd0);

        // Flush wins over a same-cycle issue and keeps the error.
        iss0(5'd1, 1'b1); iss1(5'd2, 1'b0);
        step("busy_x1_x2");
        iss0(5'd10, 1'b0);
        step("busy_x10");
        flush_all = 1'b1; iss0(5'd11, 1'b1);
        step("flush");
        check_eq("flush.busy_const", busy_vec, 32'h0);
        check_eq("flush.err_kept", {31'd0, sb_err}, 32'd1);

        iss0(5'd12, 1'b1);
        step("pre_rst");
        rst = 1'b1; iss1(5'd13, 1'b0);
        step("mid_rst");
        check_eq("mid_rst.err_const", {31'd0, sb_err}, 32'd0);

        // Random traffic over a small register window to force collisions.
        for (int c = 0; c < 3000; c++) begin
            iss0_valid = ($urandom_range(0, 99) < 45);
            iss0_rd = pick_rd(); iss0_reg_write = ($urandom_range(0, 9) < 8);
            iss0_is_load = ($urandom_range(0, 2) == 0);
            iss1_valid = ($urandom_range(0, 99) < 35);
            iss1_rd = pick_rd(); iss1_reg_write = ($urandom_range(0, 9) < 8);
            iss1_is_load = ($urandom_range(0, 2) == 0);
            wb0_valid = ($urandom_range(0, 99) < 40); wb0_rd = pick_rd();
            wb1_valid = ($urandom_range(0, 99) < 30); wb1_rd = pick_rd();
            ld_done_valid = ($urandom_range(0, 99) < 25); ld_done_rd = pick_rd();
            flush_all = ($urandom_range(0, 99) < 3);
            rst = ($urandom_range(0, 99) < 3);
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
